// File: rtl/ddr4_pkg.sv
// ddr4_pkg: shared types for the DDR4 command executor.
//   CMD_WR / CMD_RD  command instruction codes (also the MIG app_cmd values)
//   state_t          executor FSM states
//   cmd_t            queued command {instr, bl, addr}
package ddr4_pkg;

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  // Command address width; the executor's ADDR_W must equal this.
  localparam int DDR_ADDR_W = 29;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]            instr;
    logic [7:0]            bl;
    logic [DDR_ADDR_W-1:0] addr;
  } cmd_t;

  // A command is executable when it has a known opcode and at least one beat.
  function automatic logic cmd_is_valid(input cmd_t c);
    return (c.bl != 8'd0) && ((c.instr == CMD_WR) || (c.instr == CMD_RD));
  endfunction

endpackage

// File: rtl/ddr4_cmd_fifo.sv
// ddr4_cmd_fifo: synchronous FIFO holding pending commands.
//   clk, rst_n   clock, async active-low reset
//   push, din    write side (ignored when full)
//   pop, dout    read side; dout shows the head entry whenever not empty
//   full, empty  occupancy flags
//   count        number of stored entries
module ddr4_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr4_cmd_exec.sv
// ddr4_cmd_exec: queues user burst commands and expands them into per-beat
// MIG app_* transactions.
//   cmd_en/cmd_instr/cmd_bl/cmd_addr, cmd_full   user command push side
//   wr_fifo_*                                     write-data FIFO (FWFT) drain
//   rd_fifo_free, rd_fifo_wr_en, rd_fifo_din      read-data FIFO fill
//   app_*                                         MIG native interface
//   cmd_done                                      pulse on last accepted beat
//   err_sticky                                    [0] overflow, [1] bad command
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for calibration and a queued command; pops/decodes it
// ST_WR   | issuing write beats, one per cycle when data and MIG are ready
// ST_RD   | waiting for read-FIFO credit, then issuing read beats
module ddr4_cmd_exec
  import ddr4_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int ADDR_W      = DDR_ADDR_W,
  parameter int DATA_W      = 512,
  parameter int BEAT_STRIDE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_calib_complete,
  input  logic                cmd_en,
  input  logic [2:0]          cmd_instr,
  input  logic [7:0]          cmd_bl,
  input  logic [ADDR_W-1:0]   cmd_addr,
  output logic                cmd_full,
  input  logic                wr_fifo_empty,
  input  logic [DATA_W-1:0]   wr_fifo_dout,
  input  logic [DATA_W/8-1:0] wr_fifo_mask,
  output logic                wr_fifo_rd_en,
  input  logic [9:0]          rd_fifo_free,
  output logic                rd_fifo_wr_en,
  output logic [DATA_W-1:0]   rd_fifo_din,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  input  logic                app_rdy,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  output logic                cmd_done,
  output logic [1:0]          err_sticky
);

  localparam int CW = $clog2(CMD_DEPTH);
  localparam logic [CW:0] DEPTH_FULL = (CW+1)'(CMD_DEPTH);

  cmd_t        cmd_in;
  cmd_t        head;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_empty;
  logic [CW:0] cmd_count;

  state_t            state;
  logic [7:0]        cur_bl;
  logic [ADDR_W-1:0] cur_base;
  logic [7:0]        beat_cnt;
  logic              admitted;
  logic [9:0]        outstanding;

  logic              in_wr;
  logic              in_rd;
  logic              credit_ok;
  logic              rd_req;
  logic              wr_fire;
  logic              rd_fire;
  logic              beat_fire;
  logic              last_beat;

  assign cmd_in    = {cmd_instr, cmd_bl, cmd_addr};
  assign fifo_push = cmd_en && (cmd_count != DEPTH_FULL);
  assign fifo_pop  = (state == ST_IDLE) && init_calib_complete && !fifo_empty;

  ddr4_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     ($bits(cmd_t))
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (cmd_in),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (cmd_full),
    .empty (fifo_empty),
    .count (cmd_count)
  );

  assign in_wr = (state == ST_WR);
  assign in_rd = (state == ST_RD);

  // Whole-burst credit: the read FIFO must have room for everything already
  // in flight plus every beat of this command before the first read issues.
  assign credit_ok = ({1'b0, rd_fifo_free} >= ({1'b0, outstanding} + {3'b000, cur_bl}));
  assign rd_req    = in_rd && (admitted || credit_ok);
  assign wr_fire   = in_wr && !wr_fifo_empty && app_rdy && app_wdf_rdy;
  assign rd_fire   = rd_req && app_rdy;
  assign beat_fire = wr_fire || rd_fire;
  assign last_beat = (beat_cnt == (cur_bl - 8'd1));

  assign app_en        = wr_fire || rd_req;
  assign app_cmd       = in_rd ? CMD_RD : CMD_WR;
  assign app_addr      = cur_base + ADDR_W'(beat_cnt) * ADDR_W'(BEAT_STRIDE);
  assign app_wdf_wren  = wr_fire;
  assign app_wdf_end   = wr_fire;
  assign wr_fifo_rd_en = wr_fire;
  assign app_wdf_data  = in_wr ? wr_fifo_dout : '0;
  assign app_wdf_mask  = in_wr ? wr_fifo_mask : '0;
  assign cmd_done      = beat_fire && last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_bl     <= '0;
      cur_base   <= '0;
      beat_cnt   <= '0;
      admitted   <= 1'b0;
      err_sticky <= 2'b00;
    end else begin
      if (cmd_en && cmd_full) err_sticky[0] <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            cur_bl   <= head.bl;
            cur_base <= head.addr;
            beat_cnt <= '0;
            admitted <= 1'b0;
            if (!cmd_is_valid(head))       err_sticky[1] <= 1'b1;
            else if (head.instr == CMD_WR) state <= ST_WR;
            else                           state <= ST_RD;
          end
        end
        ST_WR, ST_RD: begin
          if (rd_req) admitted <= 1'b1;
          if (beat_fire) begin
            if (last_beat) state <= ST_IDLE;
            else           beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({rd_fire, app_rd_data_valid})
        2'b10:   outstanding <= outstanding + 10'd1;
        2'b01:   outstanding <= outstanding - 10'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Read return path runs independently of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_fifo_wr_en <= 1'b0;
      rd_fifo_din   <= '0;
    end else begin
      rd_fifo_wr_en <= app_rd_data_valid;
      if (app_rd_data_valid) rd_fifo_din <= app_rd_data;
    end
  end

endmodule

// File: doc/ddr4_cmd_exec.md
# ddr4_cmd_exec

Executes the burst commands issued by the user-side controller against the DDR4 MIG native (app_*) interface. Commands are queued in a 4-entry command FIFO and expanded into per-beat MIG transactions. Write beats are drained from the write-data FIFO (FWFT); read data is pushed into the read-data FIFO. Sits between the user controller and the MIG, and is the responder for the cmd_en/cmd_instr/cmd_bl/cmd_addr protocol.

## Interface
- CMD_DEPTH, 4: command FIFO entries (power of 2).
- ADDR_W, 29: MIG address width.
- DATA_W, 512: app data width; mask width is DATA_W/8.
- BEAT_STRIDE, 8: address increment per 512-bit beat.
- clk  in  1  MIG ui_clk.
- rst_n  in  1  reset, asynchronous, active-low.
- init_calib_complete  in  1  MIG calibration done.
- cmd_en  in  1  command push strobe, one cycle per command.
- cmd_instr  in  3  0 = write, 1 = read; other codes are invalid.
- cmd_bl  in  8  beats per command.
- cmd_addr  in  ADDR_W  base address of the first beat.
- cmd_full  out  1  command FIFO full.
- wr_fifo_empty  in  1  write-data FIFO empty.
- wr_fifo_dout  in  DATA_W  write data (FWFT head).
- wr_fifo_mask  in  DATA_W/8  write mask (FWFT head).
- wr_fifo_rd_en  out  1  pops one write beat.
- rd_fifo_free  in  10  free entries in the read-data FIFO.
- rd_fifo_wr_en  out  1  read-data push.
- rd_fifo_din  out  DATA_W  read data.
- app_en, app_cmd[2:0], app_addr[ADDR_W]  out  MIG command.
- app_rdy  in  1  MIG command accept.
- app_wdf_wren, app_wdf_end, app_wdf_data[DATA_W], app_wdf_mask[DATA_W/8]  out  MIG write data.
- app_wdf_rdy  in  1  MIG write-data accept.
- app_rd_data[DATA_W], app_rd_data_valid  in  MIG read return.
- cmd_done  out  1  one-cycle pulse when the last beat of a command is accepted by the MIG.
- err_sticky  out  2  bit0 = command FIFO overflow, bit1 = invalid or zero-length command; cleared only by reset.

## Operation
- cmd_en with cmd_full = 0: {instr, bl, addr} is pushed.
- cmd_en with cmd_full = 1: the command is dropped and err_sticky[0] is set.
- FSM states: IDLE, WR, RD.
- **IDLE:**
  - Waits for init_calib_complete = 1 and a non-empty command FIFO. When both hold, pops the head into base/bl/instr registers and clears beat_cnt.
  - instr 0 → WR. instr 1 → RD.
  - Invalid instr or bl = 0: the command is discarded, err_sticky[1] is set, and the FSM stays in IDLE.
- **WR:**
  - Beat fire = !wr_fifo_empty & app_rdy & app_wdf_rdy. This condition is combinational.
  - On fire, assert together: app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en.
  - Drive app_cmd = 0, app_addr = base + BEAT_STRIDE*beat_cnt, app_wdf_data = wr_fifo_dout, app_wdf_mask = wr_fifo_mask.
- **RD:**
  - Admission gate on entry: require rd_fifo_free ≥ outstanding + bl. While this does not hold, app_en stays low.
  - Once admitted, assert app_en with app_cmd = 1 and the same address formula. A beat is issued on app_rdy.
  - outstanding is incremented per issued beat and decremented per app_rd_data_valid. Both events in the same cycle leave it unchanged.
- On acceptance of beat bl-1: pulse cmd_done and go to IDLE.
- Read return path: app_rd_data_valid/app_rd_data are registered one cycle, then drive rd_fifo_wr_en/rd_fifo_din. This is independent of the FSM, so reads may still be returning while later commands execute.
- Address arithmetic: computed modulo 2^ADDR_W, so it wraps silently.
- Unsupported: cmd_bl values that are not multiples of the DDR burst. The block issues exactly bl beats regardless.

## Timing
- Reset values:
  - app_en, app_wdf_wren, app_wdf_end, wr_fifo_rd_en, rd_fifo_wr_en, cmd_done = 0.
  - app_addr, app_wdf_data, app_wdf_mask, rd_fifo_din = 0; app_cmd = 0.
  - cmd_full = 0, err_sticky = 0. FSM = IDLE, FIFO empty, outstanding = 0.
- Command-to-first-beat latency: cmd_en at cycle 0 → pop at cycle 1 → first app_en possible at cycle 2.
- Between commands: one IDLE bubble cycle after cmd_done.
- cmd_full asserts the cycle after the push that fills the FIFO. A push and a pop in the same cycle leave the count unchanged.
- Read return latency: app_rd_data_valid → rd_fifo_wr_en is 1 cycle.
- Stall on app_rdy or app_wdf_rdy low: beat_cnt and address hold. No beat is skipped or duplicated.
- init_calib_complete falling mid-command: the current command completes; no new pop occurs.
- Reset mid-operation: all state is cleared; in-flight reads are abandoned. The MIG is reset alongside.

## Structure
- Shared package ddr4_pkg:
  - CMD_WR = 3'd0, CMD_RD = 3'd1.
  - State enum.
  - Command struct {instr, bl, addr}.
- Sub-module: ddr4_cmd_fifo, a synchronous FIFO of depth CMD_DEPTH with full/empty/count outputs.
- FSM, beat counter, credit counter and read return register live in the top level.

## Test plan
- Write: cmd {0, bl=64, addr=0}, wr FIFO preloaded with 64 beats, MIG always ready → 64 consecutive app_en/app_wdf_wren with addr 0,8,…,504; cmd_done exactly once, on beat 63.
- Read with credit: cmd {1, 64, 512}, rd_fifo_free = 40 → no app_en. Raise rd_fifo_free to 64 → 64 reads at addr 512…1016; returned data appears on rd_fifo_din one cycle after each app_rd_data_valid.
- Backpressure: random app_rdy/app_wdf_rdy and wr_fifo_empty gaps → beat order and addresses exact; wr_fifo_rd_en count = 64.
- Overflow: push 5 commands back-to-back while init_calib_complete = 0 → cmd_full high after the 4th push; the 5th is dropped; err_sticky = 2'b01.
- Invalid commands: instr = 3 and bl = 0 → no app_en; err_sticky[1] = 1; the following valid command executes normally.
- Wrap and reset: addr = 2^29−8, bl = 2 → beats at 2^29−8 and 0. Assert rst_n low mid-burst → all outputs return to reset values next cycle.
